serial_bus_slave: RTL

Serial bus slave endpoint: deserialises the address/data stream driven by the bus master, performs byte writes into a local synchronous memory, and serialises read data back to the master with a one-cycle valid strobe. Sits directly downstream of the master on the serial bus (master addr_tx/data_tx/valid_s/write_en_slave → this block; this block's data_tx/slave_valid → master data_rx/slave_valid). One instance per slave device; instances are distinguished by the upper address bits.

---
 rtl/serial_bus_slave_pkg.sv | 14 +
 rtl/serial_bus_slave_if.sv | 19 +
 rtl/serial_bus_slave_ram.sv | 18 +
 rtl/serial_bus_slave.sv | 85 ++++++++
 4 files changed

// File: rtl/serial_bus_slave_pkg.sv
// serial_bus_slave_pkg: bus geometry and FSM state constants shared by master and slave.
package serial_bus_slave_pkg;
  localparam int BUS_ADDR_W = 14;
  localparam int DATA_W     = 8;
  localparam int DATA_START = 6;
  localparam int FRAME_LEN  = 14;
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_ADDR       = 3'd1;
  localparam logic [2:0] ST_WRITE      = 3'd2;
  localparam logic [2:0] ST_RD_MEM     = 3'd3;
  localparam logic [2:0] ST_RD_LOAD    = 3'd4;
  localparam logic [2:0] ST_RESP_VALID = 3'd5;
  localparam logic [2:0] ST_RESP_DATA  = 3'd6;
endpackage

// File: rtl/serial_bus_slave_if.sv
// serial_bus_slave_if: serial bus signals between master and slave.
// frame_err exists only when SLAVE_FRAME_ERR_EN is defined.
interface serial_bus_slave_if;
  logic addr_rx;
  logic data_rx;
  logic valid;
  logic write_en;
  logic data_tx;
  logic slave_valid;
  logic slave_ready;
`ifdef SLAVE_FRAME_ERR_EN
  logic frame_err;
  modport master (output addr_rx, data_rx, valid, write_en, input data_tx, slave_valid, slave_ready, frame_err);
  modport slave (input addr_rx, data_rx, valid, write_en, output data_tx, slave_valid, slave_ready, frame_err);
`else
  modport master (output addr_rx, data_rx, valid, write_en, input data_tx, slave_valid, slave_ready);
  modport slave (input addr_rx, data_rx, valid, write_en, output data_tx, slave_valid, slave_ready);
`endif
endinterface

// File: rtl/serial_bus_slave_ram.sv
// serial_bus_slave_ram: single-port synchronous byte RAM, one-cycle read latency, write-first.
module serial_bus_slave_ram
  import serial_bus_slave_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clock) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_o <= we_i ? wdata_i : mem[addr_i];
  end
endmodule

// File: rtl/serial_bus_slave.sv
// serial_bus_slave: deserialises address/data frames, writes local RAM, serialises read data back.
// Define SLAVE_FRAME_ERR_EN to add a one-cycle frame_err pulse after an aborted frame.
module serial_bus_slave
  import serial_bus_slave_pkg::*;
#(
  parameter int ADDR_W   = BUS_ADDR_W,
  parameter int MEM_AW   = 12,
  parameter int SLAVE_ID = 0
) (
  input logic clock,
  input logic rst_n,
  serial_bus_slave_if.slave bus
);
  localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);
  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdat_q, sh_q, rdata;
  logic              wr_q, valid_q;
  logic rise, abort, id_ok, shift_en;
  assign rise     = bus.valid & ~valid_q;
  assign abort    = (state_q == ST_ADDR) & ~bus.valid;
  assign id_ok    = addr_q[ADDR_W-1:MEM_AW] == (ADDR_W-MEM_AW)'(SLAVE_ID);
  assign shift_en = (state_q == ST_IDLE && rise) || state_q == ST_ADDR;
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:       state_d = rise ? ST_ADDR : ST_IDLE;
      ST_ADDR:       state_d = abort ? ST_IDLE : cnt_q == LAST ? (wr_q ? ST_WRITE : ST_RD_MEM) : ST_ADDR;
      ST_RD_MEM:     state_d = id_ok ? ST_RD_LOAD : ST_IDLE;
      ST_RD_LOAD:    state_d = ST_RESP_VALID;
      ST_RESP_VALID: state_d = ST_RESP_DATA;
      ST_RESP_DATA:  state_d = cnt_q[2:0] == 3'd7 ? ST_IDLE : ST_RESP_DATA;
      default:       state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      sh_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= bus.valid;
      if (shift_en) addr_q <= {addr_q[ADDR_W-2:0], bus.addr_rx};
      if (state_q == ST_IDLE && rise) begin
        wr_q  <= bus.write_en;
        cnt_q <= 4'd1;
      end
      if (state_q == ST_ADDR) begin
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q >= 4'(DATA_START)) wdat_q <= {wdat_q[DATA_W-2:0], bus.data_rx};
      end
      if (state_q == ST_RD_LOAD) sh_q <= rdata;
      if (state_q == ST_RESP_VALID) cnt_q <= '0;
      if (state_q == ST_RESP_DATA) begin
        sh_q  <= {sh_q[DATA_W-2:0], 1'b0};
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end
  // ID check and the RAM access both happen in frame cycle 14, once the full address is in
  serial_bus_slave_ram #(.AW(MEM_AW)) u_ram (
    .clock  (clock),
    .we_i   (state_q == ST_WRITE && id_ok),
    .addr_i (addr_q[MEM_AW-1:0]),
    .wdata_i(wdat_q),
    .rdata_o(rdata)
  );
  assign bus.data_tx     = state_q == ST_RESP_DATA && sh_q[DATA_W-1];
  assign bus.slave_valid = state_q == ST_RESP_VALID;
  assign bus.slave_ready = state_q == ST_IDLE;
`ifdef SLAVE_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) frame_err_q <= 1'b0;
    else frame_err_q <= abort;
  end
  assign bus.frame_err = frame_err_q;
`endif
endmodule
